// File: rtl/cpu_run_controller.sv
// Run controller for the multi-cycle MIPS datapath: stretches reset to the CPU,
// runs it, counts run cycles, and stops on halt or watchdog expiry.
module cpu_run_controller #(
  parameter int unsigned RESET_CYCLES   = 5,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic             halt_in,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  // Wide enough that count+1 and the watchdog limit compare without truncation
  localparam int unsigned CMP_W  = (CNT_W + 1 > 32) ? CNT_W + 1 : 32;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_IDLE,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } state_e;

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;

  logic [CNT_W-1:0]   cnt_inc;
  logic               timeout_hit;

  // State and registered outputs
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      cnt_q       <= '0;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      cnt_q       <= cnt_d;
      cpu_reset_q <= cpu_reset_d;
      running_q   <= running_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next state; outputs follow the state being entered so they stay registered
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    cnt_d       = cnt_q;
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    timeout_hit = (TIMEOUT_CYCLES != 0) &&
                  ((CMP_W'(cnt_q) + CMP_W'(1)) == CMP_W'(TIMEOUT_CYCLES));

    case (state_q)
      ST_HOLD: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (hold_cnt_q == HOLD_W'(RESET_CYCLES - 1)) begin
          state_d    = AUTO_START ? ST_RUN : ST_IDLE;
          hold_cnt_d = '0;
        end
      end
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_inc;
        // Halt takes priority over a coincident watchdog expiry
        if (halt_in) begin
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_DONE, ST_TIMEOUT: begin
        if (start) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
          cnt_d      = '0;
        end
      end
      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
        cnt_d      = '0;
      end
    endcase

    cpu_reset_d = (state_d != ST_RUN);
    running_d   = (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
    timeout_d   = (state_d == ST_TIMEOUT);
  end

  assign cpu_reset   = cpu_reset_q;
  assign running     = running_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: three instances cover auto-start, start-gated
// and narrow saturating-counter configurations.
module tb_cpu_run_controller;

  logic clk = 1'b0;
  always #2 clk = ~clk;

  logic        rst_a = 1'b0, start_a = 1'b0, halt_a = 1'b0;
  logic        cpu_reset_a, running_a, done_a, timeout_a;
  logic [31:0] count_a;

  logic        rst_b = 1'b0, start_b = 1'b0, halt_b = 1'b0;
  logic        cpu_reset_b, running_b, done_b, timeout_b;
  logic [31:0] count_b;

  logic        rst_c = 1'b0, start_c = 1'b0, halt_c = 1'b0;
  logic        cpu_reset_c, running_c, done_c, timeout_c;
  logic [3:0]  count_c;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_q[$];

  cpu_run_controller #(.RESET_CYCLES(5), .CNT_W(32), .TIMEOUT_CYCLES(100), .AUTO_START(1'b1)) dut_a (
    .CLK(clk), .Reset(rst_a), .start(start_a), .halt_in(halt_a),
    .cpu_reset(cpu_reset_a), .running(running_a), .done(done_a),
    .timeout(timeout_a), .cycle_count(count_a));

  cpu_run_controller #(.RESET_CYCLES(5), .CNT_W(32), .TIMEOUT_CYCLES(100), .AUTO_START(1'b0)) dut_b (
    .CLK(clk), .Reset(rst_b), .start(start_b), .halt_in(halt_b),
    .cpu_reset(cpu_reset_b), .running(running_b), .done(done_b),
    .timeout(timeout_b), .cycle_count(count_b));

  cpu_run_controller #(.RESET_CYCLES(5), .CNT_W(4), .TIMEOUT_CYCLES(0), .AUTO_START(1'b1)) dut_c (
    .CLK(clk), .Reset(rst_c), .start(start_c), .halt_in(halt_c),
    .cpu_reset(cpu_reset_c), .running(running_c), .done(done_c),
    .timeout(timeout_c), .cycle_count(count_c));

  // Polls dut_a's counter at falling edges until it reaches target
  task automatic wait_count_a(input logic [31:0] target, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (count_a === target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic restart_a(output bit ok);
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (running_a === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #19;
    n_checks++;
    if (cpu_reset_a !== 1'b1 || running_a !== 1'b0 || done_a !== 1'b0 ||
        timeout_a !== 1'b0 || count_a !== 32'd0)
      $display("FAIL reset_state: got cpu_reset=%b running=%b done=%b timeout=%b count=%0d, want 1 0 0 0 0",
               cpu_reset_a, running_a, done_a, timeout_a, count_a);
    else n_pass++;
    rst_a = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (cpu_reset_a !== (i < 5) || running_a !== (i == 5))
        $display("FAIL hold_edge%0d: got cpu_reset=%b running=%b, want %b %b",
                 i, cpu_reset_a, running_a, i < 5, i == 5);
      else n_pass++;
    end
  endtask

  task automatic test_halt();
    bit ok;
    logic [31:0] exp;
    @(negedge clk);
    wait_count_a(32'd10, ok);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n_checks++;
    if (!ok || running_a !== 1'b1 || cpu_reset_a !== 1'b0 || count_a !== 32'd11)
      $display("FAIL start_in_run: got running=%b cpu_reset=%b count=%0d, want 1 0 11",
               running_a, cpu_reset_a, count_a);
    else n_pass++;
    wait_count_a(32'd36, ok);
    halt_a = 1'b1;
    exp_q.push_back(32'd37);
    @(negedge clk);
    halt_a = 1'b0;
    for (int k = 0; k < 10 && done_a !== 1'b1; k++) @(negedge clk);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || done_a !== 1'b1 || count_a !== exp || cpu_reset_a !== 1'b1 ||
        running_a !== 1'b0 || timeout_a !== 1'b0)
      $display("FAIL halt37: got done=%b count=%0d cpu_reset=%b running=%b timeout=%b, want 1 %0d 1 0 0",
               done_a, count_a, cpu_reset_a, running_a, timeout_a, exp);
    else n_pass++;
    halt_a = 1'b1;
    repeat (3) @(negedge clk);
    halt_a = 1'b0;
    @(negedge clk);
    n_checks++;
    if (done_a !== 1'b1 || count_a !== exp || timeout_a !== 1'b0)
      $display("FAIL done_frozen: got done=%b count=%0d timeout=%b, want 1 %0d 0",
               done_a, count_a, timeout_a, exp);
    else n_pass++;
  endtask

  task automatic test_restart();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n_checks++;
    if (cpu_reset_a !== 1'b1 || running_a !== 1'b0 || done_a !== 1'b0 || count_a !== 32'd0)
      $display("FAIL restart_hold: got cpu_reset=%b running=%b done=%b count=%0d, want 1 0 0 0",
               cpu_reset_a, running_a, done_a, count_a);
    else n_pass++;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (cpu_reset_a !== (i < 5) || running_a !== (i == 5))
        $display("FAIL rehold_edge%0d: got cpu_reset=%b running=%b, want %b %b",
                 i, cpu_reset_a, running_a, i < 5, i == 5);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int edges;
    logic [31:0] exp;
    exp_q.push_back(32'd100);
    edges = 0;
    while (timeout_a !== 1'b1 && edges < 300) begin
      @(posedge clk);
      #1;
      edges++;
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (edges != 100)
      $display("FAIL timeout_edges: got %0d run edges, want 100", edges);
    else n_pass++;
    n_checks++;
    if (timeout_a !== 1'b1 || done_a !== 1'b0 || count_a !== exp ||
        running_a !== 1'b0 || cpu_reset_a !== 1'b1)
      $display("FAIL timeout_state: got timeout=%b done=%b count=%0d running=%b cpu_reset=%b, want 1 0 %0d 0 1",
               timeout_a, done_a, count_a, running_a, cpu_reset_a, exp);
    else n_pass++;
    @(negedge clk);
    halt_a = 1'b1;
    repeat (2) @(negedge clk);
    halt_a = 1'b0;
    n_checks++;
    if (timeout_a !== 1'b1 || done_a !== 1'b0 || count_a !== exp)
      $display("FAIL timeout_sticky: got timeout=%b done=%b count=%0d, want 1 0 %0d",
               timeout_a, done_a, count_a, exp);
    else n_pass++;
  endtask

  task automatic test_coincident();
    bit ok, ok2;
    logic [31:0] exp;
    restart_a(ok);
    wait_count_a(32'd99, ok2);
    halt_a = 1'b1;
    exp_q.push_back(32'd100);
    @(negedge clk);
    halt_a = 1'b0;
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || !ok2 || done_a !== 1'b1 || timeout_a !== 1'b0 || count_a !== exp)
      $display("FAIL halt_and_timeout: got done=%b timeout=%b count=%0d, want 1 0 %0d",
               done_a, timeout_a, count_a, exp);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    bit ok, ok2;
    restart_a(ok);
    wait_count_a(32'd20, ok2);
    rst_a = 1'b1;
    #1;
    n_checks++;
    if (!ok || !ok2 || cpu_reset_a !== 1'b1 || count_a !== 32'd0 || running_a !== 1'b0)
      $display("FAIL async_reset: got cpu_reset=%b count=%0d running=%b, want 1 0 0",
               cpu_reset_a, count_a, running_a);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic test_idle_start();
    bit held, ok;
    logic [31:0] exp;
    @(negedge clk);
    rst_b = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (cpu_reset_b !== 1'b1 || running_b !== 1'b0) held = 1'b0;
    end
    n_checks++;
    if (!held)
      $display("FAIL idle_hold: cpu_reset dropped without start (now cpu_reset=%b running=%b), want 1 0",
               cpu_reset_b, running_b);
    else n_pass++;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n_checks++;
    if (running_b !== 1'b1 || cpu_reset_b !== 1'b0 || count_b !== 32'd0)
      $display("FAIL idle_start: got running=%b cpu_reset=%b count=%0d, want 1 0 0",
               running_b, cpu_reset_b, count_b);
    else n_pass++;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (count_b === 32'd9) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    halt_b = 1'b1;
    exp_q.push_back(32'd10);
    @(negedge clk);
    halt_b = 1'b0;
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || done_b !== 1'b1 || count_b !== exp)
      $display("FAIL idle_halt: got done=%b count=%0d, want 1 %0d", done_b, count_b, exp);
    else n_pass++;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n_checks++;
    if (done_b !== 1'b0 || count_b !== 32'd0 || cpu_reset_b !== 1'b1)
      $display("FAIL done_restart: got done=%b count=%0d cpu_reset=%b, want 0 0 1",
               done_b, count_b, cpu_reset_b);
    else n_pass++;
    repeat (10) @(negedge clk);
    n_checks++;
    if (cpu_reset_b !== 1'b1 || running_b !== 1'b0)
      $display("FAIL back_to_idle: got cpu_reset=%b running=%b, want 1 0", cpu_reset_b, running_b);
    else n_pass++;
  endtask

  task automatic test_saturate();
    bit ok;
    logic [31:0] exp;
    @(negedge clk);
    rst_c = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (running_c === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    exp_q.push_back(32'd15);
    repeat (40) @(negedge clk);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || count_c !== 4'(exp) || timeout_c !== 1'b0 || running_c !== 1'b1)
      $display("FAIL saturate: got count=%0d timeout=%b running=%b, want %0d 0 1",
               count_c, timeout_c, running_c, exp);
    else n_pass++;
  endtask

  initial begin
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    test_reset();
    test_halt();
    test_restart();
    test_timeout();
    test_coincident();
    test_async_reset();
    test_idle_start();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
